// File: rtl/port_pkg.sv
// rtl/port_pkg.sv - shared defaults and helpers for router ports
package port_pkg;

  localparam int PORT_WORD_WIDTH    = 8;
  localparam int PORT_BUFFER_LENGTH = 8;
  localparam int PORT_NUM_VC        = 4;

  // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single virtual-channel circular buffer
// Ports:
//   clk_i, rstn_i   clock and synchronous active-low reset
//   push_i, data_i  store data_i at the write pointer (caller guarantees !full_o)
//   pop_i           advance the read pointer (caller guarantees !empty_o)
//   head_o          word at the read pointer
//   full_o, empty_o occupancy flags from the registered count
module vc_fifo
  import port_pkg::*;
#(
  parameter int DEPTH     = PORT_BUFFER_LENGTH,
  parameter int LOG_DEPTH = clog2(DEPTH),
  parameter int WIDTH     = PORT_WORD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  // One extra bit so a completely full buffer is distinguishable from empty.
  logic [LOG_DEPTH:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (rstn_i && push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (LOG_DEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/vc_port.sv
// rtl/vc_port.sv - multi-VC router port with round-robin registered output
// Ports:
//   clk, rst (sync, active-low)
//   data_in, write_enable, vc_in   write link, steered by VC tag
//   read_enable                    downstream ready
//   data_out, vc_out, is_writing   registered output word, its VC, valid
//   full, vc_empty                 per-VC flags
//   empty                          all VCs empty and output stage idle
//   overflow                       one-cycle pulse after a dropped write
module vc_port
  import port_pkg::*;
#(
  parameter int BUFFER_LENGTH     = PORT_BUFFER_LENGTH,
  parameter int LOG_BUFFER_LENGTH = clog2(BUFFER_LENGTH),
  parameter int WORD_WIDTH        = PORT_WORD_WIDTH,
  parameter int NUM_VC            = PORT_NUM_VC,
  parameter int LOG_NUM_VC        = clog2(NUM_VC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic [LOG_NUM_VC-1:0] vc_in,
  input  logic                  read_enable,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic [LOG_NUM_VC-1:0] vc_out,
  output logic                  is_writing,
  output logic [NUM_VC-1:0]     full,
  output logic [NUM_VC-1:0]     vc_empty,
  output logic                  empty,
  output logic                  overflow
);

  logic [WORD_WIDTH-1:0] head_w [NUM_VC];
  logic [NUM_VC-1:0]     push_w;
  logic [NUM_VC-1:0]     pop_w;
  logic [NUM_VC-1:0]     full_w;
  logic [NUM_VC-1:0]     empty_w;

  logic [LOG_NUM_VC-1:0] last_grant_q;
  logic [LOG_NUM_VC-1:0] grant_w;
  logic                  grant_valid_w;
  logic                  load_w;

  logic [WORD_WIDTH-1:0] data_out_q;
  logic [LOG_NUM_VC-1:0] vc_out_q;
  logic                  is_writing_q;
  logic                  overflow_q;

  // Output register can accept a new word when idle or being drained.
  assign load_w = !is_writing_q || read_enable;

  // Round-robin: first non-empty VC after the last grant, wrapping.
  always_comb begin
    logic [LOG_NUM_VC-1:0] cand;
    grant_w       = last_grant_q;
    grant_valid_w = 1'b0;
    cand          = last_grant_q;
    for (int k = 1; k <= NUM_VC; k++) begin
      cand = last_grant_q + LOG_NUM_VC'(k);
      if (!grant_valid_w && !empty_w[cand]) begin
        grant_w       = cand;
        grant_valid_w = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    // Full is taken from registered count, so a same-edge pop never frees space.
    assign push_w[i] = write_enable && (vc_in == LOG_NUM_VC'(i)) && !full_w[i];
    assign pop_w[i]  = load_w && grant_valid_w && (grant_w == LOG_NUM_VC'(i));

    vc_fifo #(
      .DEPTH    (BUFFER_LENGTH),
      .LOG_DEPTH(LOG_BUFFER_LENGTH),
      .WIDTH    (WORD_WIDTH)
    ) u_fifo (
      .clk_i  (clk),
      .rstn_i (rst),
      .push_i (push_w[i]),
      .data_i (data_in),
      .pop_i  (pop_w[i]),
      .head_o (head_w[i]),
      .full_o (full_w[i]),
      .empty_o(empty_w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q   <= '0;
      vc_out_q     <= '0;
      is_writing_q <= 1'b0;
      overflow_q   <= 1'b0;
      last_grant_q <= LOG_NUM_VC'(NUM_VC - 1);
    end else begin
      overflow_q <= write_enable && full_w[vc_in];
      if (load_w) begin
        if (grant_valid_w) begin
          data_out_q   <= head_w[grant_w];
          vc_out_q     <= grant_w;
          is_writing_q <= 1'b1;
          last_grant_q <= grant_w;
        end else begin
          is_writing_q <= 1'b0;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign vc_out     = vc_out_q;
  assign is_writing = is_writing_q;
  assign overflow   = overflow_q;
  assign full       = full_w;
  assign vc_empty   = empty_w;
  assign empty      = (&empty_w) && !is_writing_q;

endmodule

// File: tb/tb_vc_port.sv
// tb/tb_vc_port.sv - scoreboard bench for vc_port
module tb_vc_port;

  localparam int NV = 4;
  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       write_enable = 1'b0;
  logic [1:0] vc_in = '0;
  logic       read_enable = 1'b0;
  logic [7:0] data_out;
  logic [1:0] vc_out;
  logic       is_writing;
  logic [3:0] full;
  logic [3:0] vc_empty;
  logic       empty;
  logic       overflow;

  always #5 clk = ~clk;

  vc_port #(
    .BUFFER_LENGTH(8), .LOG_BUFFER_LENGTH(3), .WORD_WIDTH(8), .NUM_VC(4), .LOG_NUM_VC(2)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable), .vc_in(vc_in),
    .read_enable(read_enable), .data_out(data_out), .vc_out(vc_out), .is_writing(is_writing),
    .full(full), .vc_empty(vc_empty), .empty(empty), .overflow(overflow)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: per-VC queues, a round-robin pointer and one output slot.
  logic [7:0] mq [NV][$];
  int         m_last  = NV - 1;
  bit         m_valid = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [9:0] exp_q[$];   // {vc, data} expected at the output, in order
  logic [9:0] got_q[$];   // {vc, data} actually transferred

  task automatic model_step();
    bit         pre_full;
    int         g;
    logic [9:0] e;
    if (!rst) begin
      for (int v = 0; v < NV; v++) mq[v].delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_last  = NV - 1;
      exp_q.delete();
    end else begin
      pre_full = (mq[vc_in].size() == BL);
      if (!m_valid || read_enable) begin
        g = -1;
        for (int k = 1; k <= NV; k++)
          if (g < 0 && mq[(m_last + k) % NV].size() > 0) g = (m_last + k) % NV;
        if (g >= 0) begin
          e = {2'(g), mq[g].pop_front()};
          exp_q.push_back(e);
          m_last  = g;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_ovf = write_enable && pre_full;
      if (write_enable && !pre_full) mq[vc_in].push_back(data_in);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each transfer.
  initial forever begin : monitor
    logic [3:0] mf;
    logic [3:0] me;
    logic [9:0] e;
    @(negedge clk);
    for (int v = 0; v < NV; v++) begin
      mf[v] = (mq[v].size() == BL);
      me[v] = (mq[v].size() == 0);
    end
    chk("is_writing", 32'(is_writing), 32'(m_valid));
    chk("full", 32'(full), 32'(mf));
    chk("vc_empty", 32'(vc_empty), 32'(me));
    chk("empty", 32'(empty), 32'((me == 4'hf) && !m_valid));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (rst && is_writing && read_enable) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'({vc_out, data_out}), 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_word", 32'({vc_out, data_out}), 32'(e));
      end
      got_q.push_back({vc_out, data_out});
    end
  end

  task automatic drive(input logic we, input logic [1:0] v, input logic [7:0] d, input logic re);
    write_enable = we;
    vc_in        = v;
    data_in      = d;
    read_enable  = re;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string name, input logic [9:0] want[$]);
    chk({name, "_len"}, 32'(got_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < got_q.size()) chk(name, 32'(got_q[i]), 32'(want[i]));
  endtask

  initial begin
    logic [9:0] want[$];

    // Reset then idle
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_vc_empty", 32'(vc_empty), 32'hf);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_is_writing", 32'(is_writing), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);

    // Single VC passthrough
    got_q.delete();
    drive(1'b1, 2'd2, 8'h01, 1'b1);
    chk("pt_not_yet", 32'(is_writing), 32'd0);
    drive(1'b1, 2'd2, 8'h02, 1'b1);
    chk("pt_first", 32'({is_writing, vc_out, data_out}), 32'({1'b1, 2'd2, 8'h01}));
    drive(1'b1, 2'd2, 8'h03, 1'b1);
    drive(1'b1, 2'd2, 8'h04, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("pt_empty", 32'(empty), 32'd1);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    want = '{{2'd2, 8'h01}, {2'd2, 8'h02}, {2'd2, 8'h03}, {2'd2, 8'h04}};
    chk_got("pt_seq", want);

    // Round-robin
    drive(1'b1, 2'd0, 8'hA0, 1'b0);
    drive(1'b1, 2'd0, 8'hA1, 1'b0);
    drive(1'b1, 2'd1, 8'hB0, 1'b0);
    drive(1'b1, 2'd3, 8'hD0, 1'b0);
    drive(1'b1, 2'd3, 8'hD1, 1'b0);
    got_q.delete();
    repeat (8) drive(1'b0, 2'd0, 8'h00, 1'b1);
    want = '{{2'd0, 8'hA0}, {2'd1, 8'hB0}, {2'd3, 8'hD0}, {2'd0, 8'hA1}, {2'd3, 8'hD1}};
    chk_got("rr_seq", want);

    // Fill and overflow (first word parks in the output stage)
    drive(1'b1, 2'd0, 8'hEE, 1'b0);
    for (int i = 0; i < BL; i++) drive(1'b1, 2'd1, 8'(8'h10 + i), 1'b0);
    chk("fill_full1", 32'(full[1]), 32'd1);
    drive(1'b1, 2'd1, 8'h99, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    drive(1'b1, 2'd0, 8'h77, 1'b0);
    chk("ovf_once", 32'(overflow), 32'd0);
    chk("vc0_accepted", 32'(vc_empty[0]), 32'd0);
    repeat (12) drive(1'b0, 2'd0, 8'h00, 1'b1);

    // Back-pressure hold
    drive(1'b1, 2'd2, 8'h55, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      chk("bp_hold", 32'({is_writing, vc_out, data_out}), 32'({1'b1, 2'd2, 8'h55}));
      chk("bp_vc_empty", 32'(vc_empty), 32'hf);
    end
    repeat (2) drive(1'b0, 2'd0, 8'h00, 1'b1);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) drive(1'b1, 2'd0, 8'(8'h30 + i), 1'b0);
    chk("mid_busy", 32'(is_writing), 32'd1);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    rst = 1'b1;
    chk("mid_rst_out", 32'({is_writing, vc_out, data_out}), 32'd0);
    chk("mid_rst_vc_empty", 32'(vc_empty), 32'hf);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    got_q.delete();
    drive(1'b1, 2'd1, 8'hC1, 1'b1);
    drive(1'b1, 2'd1, 8'hC2, 1'b1);
    repeat (4) drive(1'b0, 2'd0, 8'h00, 1'b1);
    want = '{{2'd1, 8'hC1}, {2'd1, 8'hC2}};
    chk_got("mid_seq", want);

    // Randomized traffic: congested phase, then mostly draining
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)), 8'($urandom),
            ($urandom_range(0, 9) < ((i < 1000) ? 3 : 8)) ? 1'b1 : 1'b0);
    end
    repeat (40) drive(1'b0, 2'd0, 8'h00, 1'b1);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vc_port.md
Name: vc_port

Overview:
- Parametrised successor to the single-buffer router port.
- Holds NUM_VC independent virtual-channel FIFOs behind one input link and one output link.
- Writes are steered by a VC tag. The output drains non-empty VCs in round-robin order through a registered valid/ready stage.
- Instantiated twice per router link: output side and input side, chained the same way as the existing port pair.

Parameters:
- BUFFER_LENGTH, 8, depth of each VC FIFO in words; must be a power of 2, at least 2.
- LOG_BUFFER_LENGTH, 3, log2(BUFFER_LENGTH).
- WORD_WIDTH, 8, data word width in bits.
- NUM_VC, 4, number of virtual channels; power of 2, at least 2.
- LOG_NUM_VC, 2, log2(NUM_VC).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising clk).
- data_in  in  WORD_WIDTH  write data.
- write_enable  in  1  write request for the current cycle.
- vc_in  in  LOG_NUM_VC  target VC of the write.
- read_enable  in  1  downstream ready; a transfer occurs when is_writing && read_enable.
- data_out  out  WORD_WIDTH  registered output word.
- vc_out  out  LOG_NUM_VC  VC of data_out.
- is_writing  out  1  data_out/vc_out valid.
- full  out  NUM_VC  per-VC full flags (count == BUFFER_LENGTH); used as per-VC back-pressure.
- vc_empty  out  NUM_VC  per-VC empty flags (count == 0).
- empty  out  1  all FIFOs empty and is_writing low.
- overflow  out  1  one-cycle pulse when a write was dropped.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - all counts and read/write pointers go to 0.
  - is_writing=0, data_out=0, vc_out=0, overflow=0.
  - full=0, vc_empty=all ones, empty=1.
  - Round-robin pointer last_grant=NUM_VC-1, so VC0 has first priority.
  - Reset mid-operation discards all buffered and in-flight words with no partial state left.
- Write:
  - On an edge where write_enable=1 and full[vc_in]=0 (pre-edge value), data_in is stored at the write pointer of VC vc_in.
  - That write pointer increments, wrapping from BUFFER_LENGTH-1 to 0.
  - If full[vc_in]=1, the word is dropped, no state changes, and overflow=1 for the following cycle.
  - Full is evaluated on the pre-edge count: a write to a full VC is rejected even if that VC is popped on the same edge.
- Output stage load condition: load = (!is_writing) || read_enable.
- When load holds and any VC is non-empty (pre-edge vc_empty):
  - grant = first non-empty VC searching last_grant+1, +2, ... modulo NUM_VC.
  - On the edge: data_out <= head of grant, vc_out <= grant, is_writing <= 1, that VC's read pointer and count advance, last_grant <= grant.
- When load holds and all VCs are empty: is_writing <= 0; data_out and vc_out hold their last values.
- When load is false (is_writing=1, read_enable=0): data_out, vc_out and is_writing hold, and no FIFO is popped.
- Simultaneous push and pop on the same VC: count is unchanged and both pointers advance.
- Only the output stage pops, so at most one pop per cycle.
- Latency:
  - A word written at edge k into an empty port appears with is_writing=1 after edge k+1.
  - Sustained throughput is one word per cycle while read_enable=1.
- Ordering: words within one VC leave in FIFO order. Across VCs the order is round-robin, with one word per grant.
- Count width is LOG_BUFFER_LENGTH+1, so full is representable. Pointers are LOG_BUFFER_LENGTH bits and wrap naturally.
- full, vc_empty and empty are combinational from registered state only; there is no path from inputs to these outputs.

Decomposition:
- Shared package port_pkg holds the default WORD_WIDTH, BUFFER_LENGTH and NUM_VC constants, plus a clog2 constant function.
- The same package is used by the router top-level and the benches.
- Sub-module vc_fifo: a single-VC circular buffer with push, pop, head, count, full and empty. It is instantiated NUM_VC times in a generate loop.
- The round-robin arbiter stays inline in vc_port.

Test Plan:
- Reset then idle:
  - after rst low for 1 edge, then high: empty=1, vc_empty=4'b1111, full=0, is_writing=0, data_out=0.
- Single VC passthrough:
  - write 8'h01..8'h04 to VC2 on consecutive edges with read_enable=1.
  - data_out is 01, 02, 03, 04 with vc_out=2 on consecutive cycles, first valid one edge after the first write.
  - empty=1 after the last word is accepted.
- Round-robin:
  - with read_enable=0, preload VC0={A0,A1}, VC1={B0}, VC3={D0,D1}, then raise read_enable.
  - Output order is A0, B0, D0, A1, D1.
- Fill and overflow:
  - write 8 words to VC1 with read_enable=0; full[1]=1.
  - A ninth write to VC1 is dropped and overflow pulses high for exactly 1 cycle.
  - A write to VC0 in the next cycle is still accepted.
- Back-pressure hold:
  - is_writing=1 with data_out=8'h55 and read_enable=0 for 3 cycles: data_out, vc_out and is_writing are stable and no vc_empty bit changes.
- Reset mid-stream:
  - assert rst low while VC0 holds 5 words and is_writing=1.
  - Next cycle: all reset values. Subsequent writes are output with no stale words.
